// File: rtl/boot_reset_sequencer.sv
// boot_reset_sequencer: staged SoC reset release (fabric, then CPU) with
// CPU reset-vector selection, reset-cause capture and a saturating
// reset-event counter.
module boot_reset_sequencer #(
  parameter int unsigned SYS_HOLD       = 16,
  parameter int unsigned CPU_HOLD       = 8,
  parameter logic [31:0] DEFAULT_VECTOR = 32'h6000_0000
) (
  input  logic        clk12,
  input  logic        reset,
  input  logic        clk_ok,
  input  logic [31:0] trimming_reset,
  input  logic        trimming_reset_ena,
  input  logic        wdt_reset_req,
  input  logic        sw_reset_req,
  output logic        sys_rst,
  output logic        cpu_rst,
  output logic [31:0] cpu_reset_vector,
  output logic        vector_misaligned,
  output logic [1:0]  reset_cause,
  output logic [7:0]  reset_count,
  output logic        seq_busy
);

  localparam logic [7:0] SYS_LAST = 8'(SYS_HOLD - 1);
  localparam logic [7:0] CPU_LAST = 8'(CPU_HOLD - 1);

  typedef enum logic [1:0] {
    ST_RESET    = 2'd0,
    ST_STRETCH  = 2'd1,
    ST_CPU_WAIT = 2'd2,
    ST_RUN      = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  hold_cnt;
  // Power-on values: the event counter starts at zero after configuration
  // and the edge detector must not see a phantom high on the first cycle.
  logic [7:0]  count_q = '0;
  logic        reset_d = 1'b0;

  logic [31:0] vec_next;
  logic        mis_next;
  logic        accept;
  logic        count_inc;

  // Vector selection rule shared by the reset-exit and internal-event paths.
  always_comb begin
    vec_next = DEFAULT_VECTOR;
    mis_next = 1'b0;
    if (trimming_reset_ena) begin
      vec_next = {trimming_reset[31:2], 2'b00};
      mis_next = |trimming_reset[1:0];
    end
  end

  // Internal reset acceptance and event counting qualifier.
  always_comb begin
    accept    = !reset && (state == ST_RUN) && (wdt_reset_req || sw_reset_req);
    count_inc = (reset && !reset_d) || accept;
  end

  // Saturating reset-event counter; external reset counts once per rising edge.
  always_ff @(posedge clk12) begin
    reset_d <= reset;
    if (count_inc && (count_q != 8'hFF))
      count_q <= count_q + 8'd1;
  end

  assign reset_count = count_q;

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk12) begin
    if (reset) begin
      state             <= ST_RESET;
      hold_cnt          <= '0;
      sys_rst           <= 1'b1;
      cpu_rst           <= 1'b1;
      seq_busy          <= 1'b1;
      cpu_reset_vector  <= DEFAULT_VECTOR;
      vector_misaligned <= 1'b0;
      reset_cause       <= 2'b01;
    end else begin
      case (state)
        ST_RESET: begin
          state             <= ST_STRETCH;
          hold_cnt          <= '0;
          cpu_reset_vector  <= vec_next;
          vector_misaligned <= mis_next;
        end
        ST_STRETCH: begin
          if (clk_ok) begin
            if (hold_cnt == SYS_LAST) begin
              state    <= ST_CPU_WAIT;
              hold_cnt <= '0;
              sys_rst  <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
        end
        ST_CPU_WAIT: begin
          if (hold_cnt == CPU_LAST) begin
            state    <= ST_RUN;
            hold_cnt <= '0;
            cpu_rst  <= 1'b0;
            seq_busy <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            state             <= ST_STRETCH;
            hold_cnt          <= '0;
            sys_rst           <= 1'b1;
            cpu_rst           <= 1'b1;
            seq_busy          <= 1'b1;
            cpu_reset_vector  <= vec_next;
            vector_misaligned <= mis_next;
            reset_cause       <= wdt_reset_req ? 2'b10 : 2'b11;
          end
        end
        default: state <= ST_RESET;
      endcase
    end
  end

endmodule

// File: doc/boot_reset_sequencer.md
Name: boot_reset_sequencer

Overview:
Sequences SoC reset release inside cram_soc and selects the CPU reset vector, including the trimming-reset override from the trimming_reset/trimming_reset_ena pins. It merges external, watchdog and software reset sources into staged resets: fabric first, then CPU. It also records the cause and count of reset events.

Parameters:
SYS_HOLD, 16, cycles sys_rst stays high after reset source removed, counted only while clk_ok=1 (range 1..255)
CPU_HOLD, 8, cycles between sys_rst release and cpu_rst release (range 1..255)
DEFAULT_VECTOR, 32'h6000_0000, CPU reset vector when trimming override disabled

Ports:
clk12  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high external reset
clk_ok  input  1  clock/PLL stable; gates SYS_HOLD counting
trimming_reset  input  32  override reset vector
trimming_reset_ena  input  1  selects trimming_reset as vector
wdt_reset_req  input  1  watchdog reset request, level
sw_reset_req  input  1  software reset request, single-cycle pulse
sys_rst  output  1  fabric/peripheral reset, active-high
cpu_rst  output  1  CPU reset, active-high
cpu_reset_vector  output  32  vector presented to CPU; stable while cpu_rst=0
vector_misaligned  output  1  trimming vector had bits[1:0]!=0
reset_cause  output  2  01 external, 10 watchdog, 11 software, 00 none since config
reset_count  output  8  saturating count of reset events
seq_busy  output  1  high in every state except RUN

Behaviour:
- Reset is synchronous, active-high; reset=1 in any state -> next state RESET, counters cleared; overrides every other input.
- Values while in RESET: sys_rst=1, cpu_rst=1, seq_busy=1, cpu_reset_vector=DEFAULT_VECTOR, vector_misaligned=0, reset_cause=01. reset_count increments once on the rising edge of reset (saturates at 255). reset_count initial value after configuration is 0 (register init).
- States: RESET, STRETCH, CPU_WAIT, RUN.
- RESET -> STRETCH on the first cycle with reset=0. In that transition cycle, latch the vector:
  - trimming_reset_ena=1: vector = {trimming_reset[31:2],2'b00}; vector_misaligned = |trimming_reset[1:0].
  - trimming_reset_ena=0: vector = DEFAULT_VECTOR; vector_misaligned=0.
  - Later changes on trimming_reset/trimming_reset_ena are ignored until the next reset event.
- STRETCH: sys_rst=1, cpu_rst=1. The hold counter increments only when clk_ok=1. Go to CPU_WAIT after SYS_HOLD counted cycles. sys_rst falls on the first CPU_WAIT cycle.
- CPU_WAIT: sys_rst=0, cpu_rst=1. Go to RUN after CPU_HOLD cycles. clk_ok is ignored.
- RUN: both resets 0, seq_busy=0.
- Internal reset events are accepted only in RUN:
  - Priority: wdt_reset_req over sw_reset_req.
  - On acceptance: next state STRETCH; reset_cause=10 (watchdog) or 11 (software); reset_count++ (saturating).
  - The vector is re-latched in the accept cycle using the same rule as RESET -> STRETCH.
  - sys_rst and cpu_rst rise 1 cycle after the request.
- Requests in STRETCH or CPU_WAIT are dropped, not queued. A wdt_reset_req still high on entry to RUN triggers a new event immediately; reset_count increments again.
- Total latency, reset falling to cpu_rst falling, with clk_ok=1 throughout: 1 + SYS_HOLD + CPU_HOLD cycles.
- clk_ok dropping mid-STRETCH freezes the counter; it resumes from the frozen value (no restart).
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Defaults, trimming_reset_ena=0, reset pulse 1 cycle -> vector 6000_0000, misaligned=0, sys_rst falls 17 cycles and cpu_rst falls 25 cycles after reset falls; reset_cause=01, reset_count=1.
2. trimming_reset=6000_0002, trimming_reset_ena=1, reset pulse -> vector 6000_0000, vector_misaligned=1, reset_count=2. Repeat with 6000_1000 -> vector 6000_1000, misaligned=0.
3. Hold clk_ok=0 for 50 cycles mid-STRETCH -> sys_rst release delayed by exactly 50 cycles; CPU_WAIT length is unchanged at 8 cycles.
4. In RUN, pulse wdt_reset_req and sw_reset_req in the same cycle -> reset_cause=10, one count increment, both resets high next cycle. A sw pulse during CPU_WAIT is ignored (cause and count unchanged).
5. Assert reset during CPU_WAIT -> RESET the next cycle, sys_rst=1; full SYS_HOLD+CPU_HOLD sequence restarts from zero.
6. Issue 300 sw_reset_req events, each after RUN is reached -> reset_count saturates at 255.
